proj_frag_fetcher: RTL

PROJ_FRAG_FETCHER -- requirements
Module: proj_frag_fetcher

---
 rtl/proj_pkg.sv | 25 ++
 rtl/proj_frag_aligner.sv | 15 +
 rtl/proj_frag_fetcher.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/proj_pkg.sv
// Shared defaults, derived word count and FSM state encoding
// for the projection fragment fetcher.
package proj_pkg;

  localparam int FRAG_LEN_DEF          = 64;
  localparam int MEM_WIDTH_DEF         = 32;
  localparam int MEM_DEPTH_DEF         = 32;
  localparam int SIGNED_INDICE_LEN_DEF = 12;

  // One extra word covers a window that straddles word boundaries.
  function automatic int nwords(input int frag_len, input int mem_width);
    return frag_len / mem_width + 1;
  endfunction

  localparam int NWORDS = nwords(FRAG_LEN_DEF, MEM_WIDTH_DEF);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_ALIGN,
    S_OUT
  } state_e;

endpackage

// File: rtl/proj_frag_aligner.sv
// Combinational shift-and-truncate of the captured word window.
// Ports: words_i (NW words, word 0 in LSBs), shamt_i (bit offset), frag_o.
module proj_frag_aligner #(
  parameter int NW        = 3,
  parameter int MEM_WIDTH = 32,
  parameter int FRAG_LEN  = 64
) (
  input  logic [NW*MEM_WIDTH-1:0]     words_i,
  input  logic [$clog2(MEM_WIDTH)-1:0] shamt_i,
  output logic [FRAG_LEN-1:0]         frag_o
);

  assign frag_o = FRAG_LEN'(words_i >> shamt_i);

endmodule

// File: rtl/proj_frag_fetcher.sv
// Fetches a FRAG_LEN-bit window starting at a signed bit index from a
// word memory, zero-padding bits outside the memory.
// Ports: clk/rst, req_valid/req_ready/req_index (request),
// mem_rd_en/mem_addr/mem_rd_data (memory), frag_valid/frag_ready/frag_data.
module proj_frag_fetcher
  import proj_pkg::*;
#(
  parameter int FRAG_LEN          = FRAG_LEN_DEF,
  parameter int MEM_WIDTH         = MEM_WIDTH_DEF,
  parameter int MEM_DEPTH         = MEM_DEPTH_DEF,
  parameter int SIGNED_INDICE_LEN = SIGNED_INDICE_LEN_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [SIGNED_INDICE_LEN-1:0] req_index,
  output logic                         mem_rd_en,
  output logic [$clog2(MEM_DEPTH)-1:0] mem_addr,
  input  logic [MEM_WIDTH-1:0]         mem_rd_data,
  output logic                         frag_valid,
  input  logic                         frag_ready,
  output logic [FRAG_LEN-1:0]          frag_data
);

  localparam int NW = nwords(FRAG_LEN, MEM_WIDTH);
  localparam int AW = $clog2(MEM_DEPTH);
  localparam int OW = $clog2(MEM_WIDTH);
  localparam int SW = $clog2(NW + 1);
  localparam int IW = SIGNED_INDICE_LEN;
  localparam int BW = NW * MEM_WIDTH;
  localparam logic [SW-1:0] LAST = SW'(NW - 1);

  state_e                state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [SW-1:0]         slot_q, slot_d;
  logic                  pend_q, pend_d;
  logic                  pend_rd_q, pend_rd_d;
  logic [SW-1:0]         pend_k_q, pend_k_d;
  logic [BW-1:0]         buf_q, buf_d;
  logic [FRAG_LEN-1:0]   frag_q, frag_d;
  logic [FRAG_LEN-1:0]   aligned;
  logic signed [31:0]    idx_ext;
  logic signed [31:0]    wk;
  logic                  slot_hit;

  // Arithmetic shift gives floor division for negative indices
  // (MEM_WIDTH is a power of two).
  assign idx_ext  = {{(32-IW){idx_q[IW-1]}}, idx_q};
  assign wk       = (idx_ext >>> OW) + $signed(32'(slot_q));
  assign slot_hit = (state_q == S_FETCH) && (wk >= 0) && (wk < MEM_DEPTH);

  assign req_ready  = (state_q == S_IDLE) && !rst;
  assign mem_rd_en  = slot_hit;
  assign mem_addr   = slot_hit ? wk[AW-1:0] : '0;
  assign frag_valid = (state_q == S_OUT);
  assign frag_data  = frag_q;

  // Low index bits are the non-negative offset in two's complement.
  proj_frag_aligner #(
    .NW        (NW),
    .MEM_WIDTH (MEM_WIDTH),
    .FRAG_LEN  (FRAG_LEN)
  ) u_aligner (
    .words_i (buf_q),
    .shamt_i (idx_q[OW-1:0]),
    .frag_o  (aligned)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    slot_d    = slot_q;
    pend_d    = 1'b0;
    pend_rd_d = 1'b0;
    pend_k_d  = pend_k_q;
    buf_d     = buf_q;
    frag_d    = frag_q;

    // A slot's data arrives the cycle after it; skipped slots load zero.
    for (int k = 0; k < NW; k++) begin
      if (pend_q && pend_k_q == SW'(k)) begin
        buf_d[k*MEM_WIDTH +: MEM_WIDTH] = pend_rd_q ? mem_rd_data : '0;
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          state_d = S_FETCH;
          idx_d   = req_index;
          slot_d  = '0;
        end
      end
      S_FETCH: begin
        pend_d    = 1'b1;
        pend_rd_d = slot_hit;
        pend_k_d  = slot_q;
        slot_d    = slot_q + 1'b1;
        if (slot_q == LAST) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        state_d = S_ALIGN;
      end
      S_ALIGN: begin
        frag_d  = aligned;
        state_d = S_OUT;
      end
      S_OUT: begin
        if (frag_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      slot_q    <= '0;
      pend_q    <= 1'b0;
      pend_rd_q <= 1'b0;
      pend_k_q  <= '0;
      buf_q     <= '0;
      frag_q    <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      slot_q    <= slot_d;
      pend_q    <= pend_d;
      pend_rd_q <= pend_rd_d;
      pend_k_q  <= pend_k_d;
      buf_q     <= buf_d;
      frag_q    <= frag_d;
    end
  end

endmodule
